vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Produces the raster coordinates x/y that feed draw_board, plus hsync/vsync/blank_n/vga_clk for the video DAC.
- Sync and blank outputs are delayed by a programmable number of pixel ticks so they stay aligned with draw_board's RGB, which is late because of its RAM read latency.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing constants, coordinate type and the
// sync bundle carried through the alignment delay line.
package vga_pkg;

  localparam int HTOTAL = 800;
  localparam int VTOTAL = 525;

  localparam int H_RES = 640;
  localparam int H_FP  = 16;
  localparam int H_SW  = 96;
  localparam int H_BP  = 48;
  localparam int V_RES = 480;
  localparam int V_FP  = 10;
  localparam int V_SW  = 2;
  localparam int V_BP  = 33;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
  } sync_t;

  // Idle level of the sync bundle: syncs inactive (high), video blanked.
  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, bl: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/video signal bundle between the timing generator (master) and its
// consumers such as draw_board and the video DAC (slave).
interface vga_timing_gen_if;
  import vga_pkg::*;

  coord_t x;
  coord_t y;
  logic   active;
  logic   vga_clk;
  logic   hsync;
  logic   vsync;
  logic   blank_n;
  logic   sync_n;
  logic   line_start;
  logic   frame_start;

  modport master (
    output x, y, active, vga_clk, hsync, vsync, blank_n, sync_n,
    output line_start, frame_start
  );

  modport slave (
    input x, y, active, vga_clk, hsync, vsync, blank_n, sync_n,
    input line_start, frame_start
  );

endinterface

// File: rtl/vga_delay_line.sv
// DEPTH-stage shift register advanced on en, with async active-low reset of
// every stage to RST_VAL; DEPTH=0 is a straight wire.
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate counters from a clk/2 enable, undelayed x/y/active
// and start pulses, and sync/blank delayed to match draw_board's RGB latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HRES       = H_RES,
  parameter int HFP        = H_FP,
  parameter int HSW        = H_SW,
  parameter int HBP        = H_BP,
  parameter int VRES       = V_RES,
  parameter int VFP        = V_FP,
  parameter int VSW        = V_SW,
  parameter int VBP        = V_BP,
  parameter int PIPE_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int     HTOT   = HRES + HFP + HSW + HBP;
  localparam int     VTOT   = VRES + VFP + VSW + VBP;
  localparam coord_t H_LAST = coord_t'(HTOT - 1);
  localparam coord_t V_LAST = coord_t'(VTOT - 1);
  localparam coord_t H_VIS  = coord_t'(HRES);
  localparam coord_t V_VIS  = coord_t'(VRES);
  localparam coord_t HS_ON  = coord_t'(HRES + HFP);
  localparam coord_t HS_OFF = coord_t'(HRES + HFP + HSW);
  localparam coord_t VS_ON  = coord_t'(VRES + VFP);
  localparam coord_t VS_OFF = coord_t'(VRES + VFP + VSW);

  logic   pix_en;
  coord_t h_cnt, v_cnt;
  coord_t h_next, v_next;
  logic   h_wrap, v_wrap;
  logic   hs_raw, vs_raw, active;
  logic   hs_next, vs_next, active_next;
  logic   line_start, frame_start;
  sync_t  raw, dly;

  always_comb begin
    h_wrap      = (h_cnt == H_LAST);
    v_wrap      = (v_cnt == V_LAST);
    h_next      = h_wrap ? '0 : h_cnt + 10'd1;
    v_next      = v_cnt;
    if (h_wrap) v_next = v_wrap ? '0 : v_cnt + 10'd1;
    // Timing flags follow the counter values they will be registered with.
    hs_next     = !((h_next >= HS_ON) && (h_next < HS_OFF));
    vs_next     = !((v_next >= VS_ON) && (v_next < VS_OFF));
    active_next = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        h_cnt       <= h_next;
        v_cnt       <= v_next;
        hs_raw      <= hs_next;
        vs_raw      <= vs_next;
        active      <= active_next;
        line_start  <= h_wrap;
        frame_start <= h_wrap & v_wrap;
      end
    end
  end

  assign raw = '{hs: hs_raw, vs: vs_raw, bl: active};

  vga_delay_line #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (SYNC_RST)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (pix_en),
    .d   (raw),
    .q   (dly)
  );

  assign vga.x           = h_cnt;
  assign vga.y           = v_cnt;
  assign vga.active      = active;
  assign vga.vga_clk     = pix_en;
  assign vga.hsync       = dly.hs;
  assign vga.vsync       = dly.vs;
  assign vga.blank_n     = dly.bl;
  assign vga.sync_n      = 1'b0;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (PIPE_DELAY=2) and a shrunken
// raster instance (PIPE_DELAY=0), each tracked against a reference model.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();

  vga_timing_gen #(
    .HRES(640), .HFP(16), .HSW(96), .HBP(48),
    .VRES(480), .VFP(10), .VSW(2),  .VBP(33), .PIPE_DELAY(2)
  ) u_dut_a (.clk(clk), .rst(rst_n), .vga(ifa));

  vga_timing_gen #(
    .HRES(16), .HFP(4), .HSW(6), .HBP(4),
    .VRES(6),  .VFP(2), .VSW(2), .VBP(3), .PIPE_DELAY(0)
  ) u_dut_b (.clk(clk), .rst(rst_n), .vga(ifb));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       pix;
    logic [9:0] h;
    logic [9:0] v;
    logic       act;
    logic       ls;
    logic       fs;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, int htot, int vtot, int hres, int vres);
    mdl_t n;
    n    = m;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (m.pix) begin
      if (int'(m.h) == htot - 1) begin
        n.h  = '0;
        n.ls = 1'b1;
        if (int'(m.v) == vtot - 1) begin
          n.v  = '0;
          n.fs = 1'b1;
        end else begin
          n.v = m.v + 10'd1;
        end
      end else begin
        n.h = m.h + 10'd1;
      end
      n.act = (int'(n.h) < hres) && (int'(n.v) < vres);
    end
    n.pix = ~m.pix;
    return n;
  endfunction

  function automatic logic [2:0] raw3(logic [9:0] h, logic [9:0] v, logic act,
                                      int hs_on, int hs_w, int vs_on, int vs_w);
    logic hs, vs;
    hs = !((int'(h) >= hs_on) && (int'(h) < hs_on + hs_w));
    vs = !((int'(v) >= vs_on) && (int'(v) < vs_on + vs_w));
    return {hs, vs, act};
  endfunction

  function automatic logic [31:0] pack_out(logic [9:0] x, logic [9:0] y, logic act,
                                           logic vclk, logic [2:0] sync3, logic sn,
                                           logic ls, logic fs);
    return {4'b0, x, y, act, vclk, sync3, sn, ls, fs};
  endfunction

  // Scoreboard: each pixel tick pushes the model's raw sync triple and pops the
  // one that must now be visible on hsync/vsync/blank_n.
  logic [2:0] exp_q_a[$];
  logic [2:0] exp_q_b[$];
  mdl_t       ma, mb;
  logic [2:0] dly_a, dly_b;
  logic       tick_a, tick_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      ma    = '0;
      mb    = '0;
      dly_a = 3'b110;
      dly_b = 3'b110;
      exp_q_a.delete();
      exp_q_b.delete();
      for (int i = 0; i < 2; i++) exp_q_a.push_back(3'b110);
    end else begin
      tick_a = ma.pix;
      ma     = mdl_step(ma, 800, 525, 640, 480);
      if (tick_a) begin
        exp_q_a.push_back(raw3(ma.h, ma.v, ma.act, 656, 96, 490, 2));
        dly_a = exp_q_a.pop_front();
      end
      tick_b = mb.pix;
      mb     = mdl_step(mb, 30, 13, 16, 6);
      if (tick_b) begin
        exp_q_b.push_back(raw3(mb.h, mb.v, mb.act, 20, 6, 8, 2));
        dly_b = exp_q_b.pop_front();
      end
    end
    check("a_outputs",
          pack_out(ifa.x, ifa.y, ifa.active, ifa.vga_clk, {ifa.hsync, ifa.vsync, ifa.blank_n},
                   ifa.sync_n, ifa.line_start, ifa.frame_start),
          pack_out(ma.h, ma.v, ma.act, ma.pix, dly_a, 1'b0, ma.ls, ma.fs));
    check("b_outputs",
          pack_out(ifb.x, ifb.y, ifb.active, ifb.vga_clk, {ifb.hsync, ifb.vsync, ifb.blank_n},
                   ifb.sync_n, ifb.line_start, ifb.frame_start),
          pack_out(mb.h, mb.v, mb.act, mb.pix, dly_b, 1'b0, mb.ls, mb.fs));
  end

  // ---------------- timing-constant checks (clk counts) ----------------
  int   a_hs_run, a_ls_cnt;
  logic a_hs_prev, a_bl_prev, a_ls_have;
  int   b_vs_run, b_fs_cnt, b_bl_cnt;
  logic b_hs_prev, b_vs_prev, b_bl_prev, b_fs_have;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_hs_run = 0; a_ls_cnt = 0; a_hs_prev = 1'b1; a_bl_prev = 1'b0; a_ls_have = 1'b0;
      b_vs_run = 0; b_fs_cnt = 0; b_bl_cnt = 0;
      b_hs_prev = 1'b1; b_vs_prev = 1'b1; b_bl_prev = 1'b0; b_fs_have = 1'b0;
    end else begin
      if (!ifa.hsync) a_hs_run++;
      if (!ifa.hsync && a_hs_prev) check("a_hs_fall_x", {22'b0, ifa.x}, 32'd658);
      if (ifa.hsync && !a_hs_prev) begin
        check("a_hs_width_clk", a_hs_run, 32'd192);
        a_hs_run = 0;
      end
      if (!ifa.blank_n && a_bl_prev) check("a_bl_fall_x", {22'b0, ifa.x}, 32'd642);
      a_ls_cnt++;
      if (ifa.line_start) begin
        if (a_ls_have) check("a_line_period_clk", a_ls_cnt, 32'd1600);
        a_ls_have = 1'b1;
        a_ls_cnt  = 0;
      end
      a_hs_prev = ifa.hsync;
      a_bl_prev = ifa.blank_n;

      if (!ifb.hsync && b_hs_prev) check("b_hs_fall_x", {22'b0, ifb.x}, 32'd20);
      if (!ifb.blank_n && b_bl_prev) check("b_bl_fall_x", {22'b0, ifb.x}, 32'd16);
      if (!ifb.vsync) b_vs_run++;
      if (!ifb.vsync && b_vs_prev) check("b_vs_fall_xy", {12'b0, ifb.x, ifb.y}, {12'b0, 10'd0, 10'd8});
      if (ifb.vsync && !b_vs_prev) begin
        check("b_vs_width_clk", b_vs_run, 32'd120);
        b_vs_run = 0;
      end
      b_fs_cnt++;
      if (ifb.frame_start) begin
        if (b_fs_have) begin
          check("b_frame_period_clk", b_fs_cnt, 32'd780);
          check("b_blank_clk_per_frame", b_bl_cnt, 32'd192);
        end
        b_fs_have = 1'b1;
        b_fs_cnt  = 0;
        b_bl_cnt  = 0;
      end
      if (ifb.blank_n) b_bl_cnt++;
      b_hs_prev = ifb.hsync;
      b_vs_prev = ifb.vsync;
      b_bl_prev = ifb.blank_n;
    end
  end

  // ---------------- driver ----------------
  localparam logic [31:0] RST_OUT = {4'b0, 10'd0, 10'd0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0};

  task automatic check_reset_now(input string tag_a, input string tag_b);
    check(tag_a, pack_out(ifa.x, ifa.y, ifa.active, ifa.vga_clk,
                          {ifa.hsync, ifa.vsync, ifa.blank_n}, ifa.sync_n,
                          ifa.line_start, ifa.frame_start), RST_OUT);
    check(tag_b, pack_out(ifb.x, ifb.y, ifb.active, ifb.vga_clk,
                          {ifb.hsync, ifb.vsync, ifb.blank_n}, ifb.sync_n,
                          ifb.line_start, ifb.frame_start), RST_OUT);
  endtask

  logic found;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_reset_now("a_in_reset", "b_in_reset");
    end
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("a_vga_clk_edge1", {31'b0, ifa.vga_clk}, 32'd1);
    check("a_x_edge1", {22'b0, ifa.x}, 32'd0);
    @(negedge clk);
    check("a_vga_clk_edge2", {31'b0, ifa.vga_clk}, 32'd0);
    check("a_x_edge2", {22'b0, ifa.x}, 32'd1);

    repeat (3400) @(negedge clk);

    // Park the small raster inside both sync pulses, then hit it with reset.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (ifb.x == 10'd20 && ifb.y == 10'd8) found = 1'b1;
    end
    check("b_reach_sync_point", {31'b0, found}, 32'd1);
    check("b_syncs_low_pre_reset", {30'b0, ifb.hsync, ifb.vsync}, 32'd0);

    #1 rst_n = 1'b0;
    #1 check_reset_now("a_async_reset", "b_async_reset");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (1700) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
